// File: rtl/regfile_param_if.sv
// Register file access bundle: two read ports, one write port, clear control.
// master = datapath side driving addresses/requests, slave = register file.
interface regfile_param_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic        [ADDR_W-1:0] rd_addr1;
   logic        [ADDR_W-1:0] rd_addr2;
   logic signed [DATA_W-1:0] rd_data1;
   logic signed [DATA_W-1:0] rd_data2;
   logic                     wr_en;
   logic        [ADDR_W-1:0] wr_addr;
   logic signed [DATA_W-1:0] wr_data;
   logic                     wr_ready;
   logic                     clr_req;
   logic                     clr_busy;
   logic                     clr_done;

   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
      input  rd_data1, rd_data2, wr_ready, clr_busy, clr_done
   );

   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
      output rd_data1, rd_data2, wr_ready, clr_busy, clr_done
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: 2 comb read ports, 1 sync write port,
// hard-wired zero reg, optional non-negative clamp reg, sequential clear.
// Ports: clk, rst_n (async active-low), bus (regfile_param_if.slave).
// Optional: define REGFILE_BYPASS_EN to forward a committing write to reads.
module regfile_param #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 5,
   parameter int ZERO_REG  = 31,
   parameter int CLAMP_REG = 28
) (
   input logic            clk,
   input logic            rst_n,
   regfile_param_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W-1:0] CLAMP_IDX = ADDR_W'(CLAMP_REG);
   // Out-of-range clamp index turns the clamp off entirely.
   localparam bit CLAMP_ON = (CLAMP_REG >= 0) && (CLAMP_REG < DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ready_q, ready_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];

   logic                commit;
   logic [DATA_W-1:0]   wr_val;
   logic [DATA_W-1:0]   rd1, rd2;

   always_comb begin
      commit = bus.wr_en && ready_q && (bus.wr_addr != ZERO_IDX);
      wr_val = bus.wr_data;
      if (CLAMP_ON && (bus.wr_addr == CLAMP_IDX) && bus.wr_data[DATA_W-1])
         wr_val = '0;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ready_d = ready_q;
      mem_d   = mem_q;

      // Commit and sweep never coincide: commits need ready_q, which is
      // low for the whole CLEAR state.
      if (commit)
         mem_d[bus.wr_addr] = wr_val;

      unique case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (bus.clr_req) begin
               state_d = S_CLEAR;
               ptr_d   = '0;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end
         end
         S_CLEAR: begin
            mem_d[ptr_q] = '0;
            ptr_d        = ptr_q + 1'b1;
            if (ptr_q == '1) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               ready_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= mem_d[i];
      end
   end

   always_comb begin
      rd1 = mem_q[bus.rd_addr1];
      rd2 = mem_q[bus.rd_addr2];
`ifdef REGFILE_BYPASS_EN
      // Commit already excludes the zero reg; sweep is never forwarded.
      if (commit && (bus.rd_addr1 == bus.wr_addr))
         rd1 = wr_val;
      if (commit && (bus.rd_addr2 == bus.wr_addr))
         rd2 = wr_val;
`endif
      if (bus.rd_addr1 == ZERO_IDX)
         rd1 = '0;
      if (bus.rd_addr2 == ZERO_IDX)
         rd2 = '0;
   end

   assign bus.rd_data1 = rd1;
   assign bus.rd_data2 = rd2;
   assign bus.wr_ready = ready_q;
   assign bus.clr_busy = busy_q;
   assign bus.clr_done = done_q;

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param: directed vectors, per-cycle model compare,
// and literal expectations on the main scenarios.
module tb_regfile_param;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   bit   chk_en;
   int   busy_cnt;
   int   done_cnt;

   regfile_param_if bus ();

   regfile_param dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: array of values, plus a count of sweep cycles left.
   logic [63:0] m_mem [32];
   int          m_sweep;
   bit          m_done;

   function automatic logic [63:0] wv(input logic [4:0] a,
                                      input logic [63:0] d);
      if (a == 5'd28 && $signed(d) < 0)
         return 64'd0;
      return d;
   endfunction

   function automatic logic [63:0] exp_rd(input logic [4:0] a);
      if (a == 5'd31)
         return 64'd0;
`ifdef REGFILE_BYPASS_EN
      if (m_sweep == 0 && bus.wr_en && a == bus.wr_addr)
         return wv(a, bus.wr_data);
`endif
      return m_mem[a];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         foreach (m_mem[i]) m_mem[i] <= 64'd0;
         m_sweep <= 0;
         m_done  <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_sweep == 0 && bus.wr_en && bus.wr_addr != 5'd31)
            m_mem[bus.wr_addr] <= wv(bus.wr_addr, bus.wr_data);
         if (m_sweep > 0) begin
            m_mem[32 - m_sweep] <= 64'd0;
            m_sweep <= m_sweep - 1;
            if (m_sweep == 1)
               m_done <= 1'b1;
         end else if (!m_done && bus.clr_req) begin
            m_sweep <= 32;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   always @(negedge clk) begin
      if (bus.clr_busy) busy_cnt++;
      if (bus.clr_done) done_cnt++;
      if (chk_en) begin
         chk("m_rd1", bus.rd_data1, exp_rd(bus.rd_addr1));
         chk("m_rd2", bus.rd_data2, exp_rd(bus.rd_addr2));
         chk("m_ready", {63'd0, bus.wr_ready}, {63'd0, m_sweep == 0});
         chk("m_busy", {63'd0, bus.clr_busy}, {63'd0, m_sweep > 0});
         chk("m_done", {63'd0, bus.clr_done}, {63'd0, m_done});
      end
   end

   task automatic wr(input logic [4:0] a, input logic [63:0] d);
      @(negedge clk);
      #1;
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      @(negedge clk);
      #1;
      bus.wr_en = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      #1 bus.clr_req = 1'b1;
      @(negedge clk);
      #1 bus.clr_req = 1'b0;
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      chk_en       = 1'b0;
      busy_cnt     = 0;
      done_cnt     = 0;
      rst_n        = 1'b0;
      bus.rd_addr1 = '0;
      bus.rd_addr2 = '0;
      bus.wr_en    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.clr_req  = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      for (int i = 0; i < 32; i++) begin
         bus.rd_addr1 = 5'(i);
         #1 chk($sformatf("rst_rd%0d", i), bus.rd_data1, 64'd0);
      end
      chk("rst_ready", {63'd0, bus.wr_ready}, 64'd1);
      chk("rst_busy", {63'd0, bus.clr_busy}, 64'd0);
      chk("rst_done", {63'd0, bus.clr_done}, 64'd0);

      wr(5'd5, 64'h1234);
      bus.rd_addr1 = 5'd5;
      bus.rd_addr2 = 5'd5;
      #1;
      chk("r5_p1", bus.rd_data1, 64'h1234);
      chk("r5_p2", bus.rd_data2, 64'h1234);
      wr(5'd31, 64'd7);
      bus.rd_addr1 = 5'd31;
      #1 chk("r31_zero", bus.rd_data1, 64'd0);

      wr(5'd28, -64'sd5);
      bus.rd_addr1 = 5'd28;
      #1 chk("clamp_neg", bus.rd_data1, 64'd0);
      wr(5'd28, 64'd9);
      #1 chk("clamp_pos", bus.rd_data1, 64'd9);
      wr(5'd27, -64'sd5);
      bus.rd_addr1 = 5'd27;
      #1 chk("r27_neg", bus.rd_data1, 64'hFFFF_FFFF_FFFF_FFFB);

      for (int i = 0; i < 31; i++)
         wr(5'(i), 64'(i + 1));
      bus.rd_addr1 = 5'd3;
      bus.rd_addr2 = 5'd30;
      busy_cnt = 0;
      done_cnt = 0;
      pulse_clr();
      repeat (9) @(negedge clk);
      #1;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd3;
      bus.wr_data = 64'hDEAD;
      #1 chk("sweep_ready", {63'd0, bus.wr_ready}, 64'd0);
      @(negedge clk);
      #1 bus.wr_en = 1'b0;
      repeat (5) @(negedge clk);
      pulse_clr();
      repeat (25) @(negedge clk);
      #1;
      chk("busy_len", 64'(busy_cnt), 64'd32);
      chk("done_cnt", 64'(done_cnt), 64'd1);
      chk("r3_drop", bus.rd_data1, 64'd0);
      for (int i = 0; i < 32; i++) begin
         bus.rd_addr2 = 5'(i);
         #1 chk($sformatf("clr_rd%0d", i), bus.rd_data2, 64'd0);
      end

      wr(5'd20, 64'hAB);
      bus.rd_addr1 = 5'd20;
      pulse_clr();
      repeat (9) @(negedge clk);
      #1 chk("unswept_r20", bus.rd_data1, 64'hAB);
      rst_n = 1'b0;
      #1;
      chk("arst_ready", {63'd0, bus.wr_ready}, 64'd1);
      chk("arst_busy", {63'd0, bus.clr_busy}, 64'd0);
      chk("arst_done", {63'd0, bus.clr_done}, 64'd0);
      chk("arst_r20", bus.rd_data1, 64'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      chk("post_r20", bus.rd_data1, 64'd0);
      wr(5'd20, 64'h77);
      #1 chk("r20_wr", bus.rd_data1, 64'h77);

      wr(5'd4, 64'h11);
      @(negedge clk);
      #1;
      bus.rd_addr1 = 5'd4;
      bus.wr_en    = 1'b1;
      bus.wr_addr  = 5'd4;
      bus.wr_data  = 64'h55;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_same", bus.rd_data1, 64'h55);
`else
      chk("byp_same", bus.rd_data1, 64'h11);
`endif
      @(negedge clk);
      #1 bus.wr_en = 1'b0;
      #1 chk("byp_next", bus.rd_data1, 64'h55);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the single-cycle datapath, successor to the fixed 32x64 file. It provides two combinational read ports and one synchronous write port, a hard-wired zero register, an optional non-negative clamp register, and a sequential clear engine that zeroes the whole file one entry per cycle on request. It sits between the decode stage (read addresses) and the writeback mux (write data).

## Interface
- DATA_W, 64: register width in bits; data is signed two's complement.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 31: index that always reads 0; writes to it are discarded.
- CLAMP_REG, 28: index whose stored value is never negative. Any value >= DEPTH disables the clamp.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data (signed, combinational).
- rd_data2  out  DATA_W  read port 2 data (signed, combinational).
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data (signed).
- wr_ready  out  1  write accepted this cycle; 0 while clearing.
- clr_req  in  1  start a full-file clear (level-sampled in IDLE).
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep finishes.

## Operation
- Reset (rst_n=0, asynchronous): all entries 0, FSM=IDLE, clear pointer 0, clr_busy=0, clr_done=0, wr_ready=1.
- Reads: rd_dataN = 0 if rd_addrN==ZERO_REG, else entry[rd_addrN]. There is no latency.
- Write commit: wr_en && wr_ready && wr_addr!=ZERO_REG. On commit, entry[wr_addr] gets wr_data at the edge. If wr_addr==CLAMP_REG and wr_data<0, the entry gets 0 instead.
- FSM states:
  - IDLE: wr_ready=1. clr_req=1 goes to CLEAR with ptr=0.
  - CLEAR: wr_ready=0, clr_busy=1. Each edge sets entry[ptr]=0 and increments ptr. When ptr==DEPTH-1 is written, the FSM goes to DONE.
  - DONE: clr_done=1, wr_ready=1, and commits are allowed. The FSM goes unconditionally to IDLE.
- clr_req in CLEAR or DONE is ignored. A clear is not queued.
- clr_req and a write in the same IDLE cycle: the write commits, then the sweep later zeroes that entry.
- Reads during CLEAR return current contents. Entries not yet swept keep their old values.
- A write request while wr_ready=0 is dropped, not stalled internally. The upstream stage must hold it.
- rst_n asserted mid-sweep: the sweep is aborted immediately, all entries are 0, and the FSM is IDLE.

## Timing
- Write-to-read latency: 1 cycle (visible after the commit edge), unless bypass is compiled in.
- Clear: clr_req is sampled high at edge E. clr_busy is high for DEPTH cycles after E. clr_done is high for the single cycle after that. wr_ready is low exactly while clr_busy is high.
- The total clear cost is DEPTH+1 cycles from request to IDLE (33 with defaults).

## Configuration
- REGFILE_BYPASS_EN defined: when a write commits this cycle and rd_addrN==wr_addr (and is not ZERO_REG), rd_dataN returns the value being written, post-clamp. Each port is handled independently.
- REGFILE_BYPASS_EN undefined: read ports return the pre-edge stored value, and the new value appears the next cycle.
- Bypass never applies to the clear sweep.

## Test plan
- Reset then read all 32 addresses -> every read returns 0. wr_ready=1, clr_busy=0, clr_done=0.
- Write 0x0000_0000_0000_1234 to r5. The next cycle, read r5 on both ports -> 0x1234. Write 7 to r31, then read r31 -> 0.
- Write -5 to r28 -> reads 0. Write 9 to r28 -> reads 9. Write -5 to r27 -> reads -5 (0xFFFF_FFFF_FFFF_FFFB).
- Fill r0..r30 with index+1, then pulse clr_req:
  - clr_busy is high 32 cycles.
  - A write to r3 mid-sweep is dropped (wr_ready=0).
  - clr_done pulses once.
  - All reads return 0.
  - A second clr_req during the sweep has no effect.
- Assert rst_n=0 at sweep cycle 10 -> outputs return to reset values immediately. After release, r20 reads 0 and a write to r20 commits next edge.
- Write 0x55 to r4 with rd_addr1=4 in the same cycle:
  - With REGFILE_BYPASS_EN, rd_data1=0x55 in that cycle.
  - Without it, rd_data1 shows the old value, then 0x55 next cycle.
